// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register with saturating shift counter
module univ_shift_reg #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}},
    localparam int              CW         = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             preset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic [CW-1:0]    shift_cnt,
    output logic             drained
);

    localparam logic [1:0]    MODE_HOLD  = 2'b00;
    localparam logic [1:0]    MODE_SHR   = 2'b01;
    localparam logic [1:0]    MODE_SHL   = 2'b10;
    localparam logic [1:0]    MODE_ROR   = 2'b11;
    localparam logic [CW-1:0] CNT_FULL   = CW'(WIDTH);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             cnt_full;
    logic             moving;

    // Counter stops at WIDTH; shifting itself never stops
    assign cnt_full = (cnt_q == CNT_FULL);
    assign moving   = (mode != MODE_HOLD);

    // Next-state selection: reset > preset > load > mode
    always_comb begin
        q_d   = q_q;
        cnt_d = cnt_q;
        if (reset) begin
            q_d   = '0;
            cnt_d = '0;
        end else if (preset) begin
            q_d   = PRESET_VAL;
            cnt_d = '0;
        end else if (load) begin
            q_d   = d;
            cnt_d = '0;
        end else begin
            case (mode)
                MODE_SHR: q_d = {sin_r, q_q[WIDTH-1:1]};
                MODE_SHL: q_d = {q_q[WIDTH-2:0], sin_l};
                MODE_ROR: q_d = {q_q[0], q_q[WIDTH-1:1]};
                default:  q_d = q_q;
            endcase
            if (moving && !cnt_full) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // State registers; reset is folded into the next-state logic above
    always_ff @(posedge clk) begin
        q_q   <= q_d;
        cnt_q <= cnt_d;
    end

    assign q         = q_q;
    assign sout_r    = q_q[0];
    assign sout_l    = q_q[WIDTH-1];
    assign shift_cnt = cnt_q;
    assign drained   = cnt_full;

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - self-checking bench for univ_shift_reg
module tb_univ_shift_reg;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         preset = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] d = '0;
    logic [1:0]   mode = 2'b00;
    logic         sin_r = 1'b0;
    logic         sin_l = 1'b0;
    logic [W-1:0] q;
    logic         sout_r;
    logic         sout_l;
    logic [3:0]   shift_cnt;
    logic         drained;

    int n_pass = 0;
    int n_total = 0;

    univ_shift_reg #(.WIDTH(W), .PRESET_VAL(8'hFF)) dut (
        .clk(clk), .reset(reset), .preset(preset), .load(load), .d(d),
        .mode(mode), .sin_r(sin_r), .sin_l(sin_l), .q(q), .sout_r(sout_r),
        .sout_l(sout_l), .shift_cnt(shift_cnt), .drained(drained)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 0; preset = 0; load = 0; mode = 2'b00; sin_r = 0; sin_l = 0; d = '0;
    endtask

    task automatic do_load(input logic [W-1:0] val);
        idle();
        load = 1; d = val;
        tick();
        load = 0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1; preset = 1; load = 1; d = 8'h5A; mode = 2'b01;
        tick();
        idle();
        n_total++;
        if ({q, shift_cnt, drained} !== {8'h00, 4'd0, 1'b0})
            $display("FAIL reset: q=%h cnt=%0d drained=%b, want q=00 cnt=0 drained=0", q, shift_cnt, drained);
        else n_pass++;
    endtask

    task automatic test_shift_right();
        logic [7:0] exp_q [8];
        logic       exp_so [8];
        exp_q  = '{8'h52, 8'h29, 8'h14, 8'h0A, 8'h05, 8'h02, 8'h01, 8'h00};
        exp_so = '{1, 0, 1, 0, 0, 1, 0, 1};
        do_load(8'hA5);
        for (int i = 0; i < 8; i++) begin
            n_total++;
            if (sout_r !== exp_so[i])
                $display("FAIL shr_sout_r[%0d]: got %b want %b", i, sout_r, exp_so[i]);
            else n_pass++;
            mode = 2'b01; sin_r = 0; sin_l = 1;
            tick();
            n_total++;
            if (q !== exp_q[i] || shift_cnt !== 4'(i + 1))
                $display("FAIL shr_q[%0d]: got q=%h cnt=%0d want q=%h cnt=%0d", i, q, shift_cnt, exp_q[i], i + 1);
            else n_pass++;
        end
        n_total++;
        if (drained !== 1'b1)
            $display("FAIL shr_drained: got %b want 1", drained);
        else n_pass++;
        idle();
    endtask

    task automatic test_rotate();
        do_load(8'h81);
        mode = 2'b11; sin_r = 1; sin_l = 1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (i == 1 || i == 8 || i == 9) begin
                n_total++;
                if (q !== ((i == 8) ? 8'h81 : 8'hC0))
                    $display("FAIL ror_q[%0d]: got %h want %h", i, q, (i == 8) ? 8'h81 : 8'hC0);
                else n_pass++;
            end
        end
        n_total++;
        if (shift_cnt !== 4'd8 || drained !== 1'b1)
            $display("FAIL ror_cnt_sat: got cnt=%0d drained=%b want 8/1", shift_cnt, drained);
        else n_pass++;
        idle();
    endtask

    task automatic test_shift_left();
        logic [7:0] exp_q [3];
        exp_q = '{8'h03, 8'h07, 8'h0F};
        do_load(8'h01);
        for (int i = 0; i < 3; i++) begin
            mode = 2'b10; sin_l = 1; sin_r = 1;
            tick();
            n_total++;
            if (q !== exp_q[i] || sout_l !== 1'b0)
                $display("FAIL shl_q[%0d]: got q=%h sout_l=%b want q=%h sout_l=0", i, q, sout_l, exp_q[i]);
            else n_pass++;
        end
        n_total++;
        if (shift_cnt !== 4'd3 || drained !== 1'b0)
            $display("FAIL shl_cnt: got cnt=%0d drained=%b want 3/0", shift_cnt, drained);
        else n_pass++;
        idle();
    endtask

    task automatic test_priority();
        idle();
        preset = 1; load = 1; d = 8'h00; mode = 2'b01;
        tick();
        n_total++;
        if (q !== 8'hFF || shift_cnt !== 4'd0)
            $display("FAIL preset_over_load: got q=%h cnt=%0d want FF/0", q, shift_cnt);
        else n_pass++;
        idle();
        mode = 2'b10; tick();
        load = 1; d = 8'h3C; mode = 2'b11;
        tick();
        n_total++;
        if (q !== 8'h3C || shift_cnt !== 4'd0)
            $display("FAIL load_over_mode: got q=%h cnt=%0d want 3C/0", q, shift_cnt);
        else n_pass++;
        idle();
        reset = 1; preset = 1;
        tick();
        n_total++;
        if (q !== 8'h00 || shift_cnt !== 4'd0)
            $display("FAIL reset_over_preset: got q=%h cnt=%0d want 00/0", q, shift_cnt);
        else n_pass++;
        idle();
    endtask

    task automatic test_mid_reset();
        logic [7:0] snap_q;
        do_load(8'hC3);
        mode = 2'b01; sin_r = 1;
        repeat (4) tick();
        n_total++;
        if (shift_cnt !== 4'd4)
            $display("FAIL mid_cnt_before: got %0d want 4", shift_cnt);
        else n_pass++;
        idle();
        reset = 1;
        tick();
        idle();
        n_total++;
        if (shift_cnt !== 4'd0 || q !== 8'h00 || drained !== 1'b0)
            $display("FAIL mid_reset: got q=%h cnt=%0d drained=%b want 00/0/0", q, shift_cnt, drained);
        else n_pass++;
        do_load(8'h9D);
        mode = 2'b10; tick(); tick();
        snap_q = 8'h74;
        mode = 2'b00; sin_r = 1; sin_l = 1;
        repeat (3) tick();
        n_total++;
        if (q !== snap_q || shift_cnt !== 4'd2)
            $display("FAIL hold: got q=%h cnt=%0d want %h/2", q, shift_cnt, snap_q);
        else n_pass++;
        idle();
    endtask

    task automatic test_random();
        int m_q;
        int m_cnt;
        int errs;
        m_q = 0; m_cnt = 0; errs = 0;
        idle(); reset = 1; tick();
        for (int i = 0; i < 400; i++) begin
            reset  = ($urandom_range(0, 29) == 0);
            preset = ($urandom_range(0, 19) == 0);
            load   = ($urandom_range(0, 9) == 0);
            d      = 8'($urandom);
            mode   = 2'($urandom);
            sin_r  = 1'($urandom);
            sin_l  = 1'($urandom);
            if (reset) begin
                m_q = 0; m_cnt = 0;
            end else if (preset) begin
                m_q = 255; m_cnt = 0;
            end else if (load) begin
                m_q = int'(d); m_cnt = 0;
            end else if (mode != 2'b00) begin
                case (mode)
                    2'b01:   m_q = m_q / 2 + int'(sin_r) * 128;
                    2'b10:   m_q = (m_q * 2 + int'(sin_l)) % 256;
                    default: m_q = m_q / 2 + (m_q % 2) * 128;
                endcase
                if (m_cnt < W) m_cnt = m_cnt + 1;
            end
            tick();
            n_total++;
            if (q !== 8'(m_q) || shift_cnt !== 4'(m_cnt) || drained !== (m_cnt == W)
                || sout_r !== 1'(m_q % 2) || sout_l !== 1'(m_q / 128)) begin
                if (errs < 10)
                    $display("FAIL random[%0d]: got q=%h cnt=%0d drained=%b so=%b%b want q=%h cnt=%0d",
                             i, q, shift_cnt, drained, sout_l, sout_r, 8'(m_q), m_cnt);
                errs++;
            end else n_pass++;
        end
        idle();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_shift_right();
        test_rotate();
        test_shift_left();
        test_priority();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
